fmul_result_pack: RTL and testbench
===================================

Name: fmul_result_pack

Overview:
- Downstream stage of the single-precision multiplier.
- Accepts the multiplier's unpacked result fields (sign, biased exp, 24-bit frac with hidden bit, error, overflow) under a valid/ready handshake.
- Canonicalizes special cases and packs them into IEEE-754 binary32 words.
- Buffers results in a small elastic FIFO toward the consumer and keeps sticky exception flags for software/status readout.

Parameters:
- DEPTH, 2, buffer entries; power of two, >= 2.
- QNAN, 32'h7FC00000, canonical quiet-NaN word emitted on error.
- CNT_W, 16, width of statistics counters (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  multiplier result valid
- in_ready  out  1  stage can accept a result this cycle
- in_sign  in  1  result sign
- in_exp  in  8  biased exponent (8'hFF = inf/NaN/overflow, 0 = zero/underflow)
- in_frac  in  24  fraction incl. hidden bit [23]
- in_error  in  1  invalid operation (NaN operand, inf*0)
- in_overflow  in  1  exponent overflow
- out_valid  out  1  packed word available
- out_ready  in  1  consumer accepts word
- out_data  out  32  packed binary32
- out_flags  out  3  per-word flags {invalid, overflow, zero}
- flag_clr  in  1  clear sticky flags (and counters if enabled)
- sticky_invalid  out  1  an invalid result has been accepted since the last clear
- sticky_overflow  out  1  an overflow result has been accepted since the last clear

Behaviour:
- Reset (async assert, sync release): buffer empty, out_valid=0, out_data=0, out_flags=0, sticky flags=0, in_ready=1, pointers=0.
- Push when in_valid & in_ready. Pop when out_valid & out_ready.
- in_ready = (count != DEPTH), derived from registered count only; no combinational path from out_ready.
- Latency: word pushed at edge N is visible on out_data after edge N when the buffer was empty. No bypass.
- out_data and out_flags are driven from the head entry and held stable while out_valid & !out_ready.
- Packing priority, evaluated at push:
  1. in_error -> QNAN; flags 3'b100. The upstream NaN frac has [22:0]=0, so raw packing would produce infinity; the override is mandatory.
  2. in_overflow -> {in_sign, 8'hFF, 23'h0}; flags 3'b010.
  3. in_exp==8'hFF (inf*inf) -> {in_sign, 8'hFF, 23'h0}; flags 3'b000.
  4. in_exp==0 -> {in_sign, 31'h0}; flags 3'b001.
  5. Otherwise -> {in_sign, in_exp, in_frac[22:0]}; flags 3'b000. in_frac[23] is ignored.
- Simultaneous push and pop: allowed when count is between 1 and DEPTH-1 (count unchanged). When full, no push is possible that cycle; in_ready rises the cycle after a pop.
- Pointers wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits.
- Sticky flags: set on push of a word whose flag bit is 1. flag_clr clears. If a set and flag_clr occur in the same cycle, set wins.
- Reset mid-stream: buffered words are discarded and no partial output is produced.

Optional Feature:
- Macro FMUL_PACK_STATS_EN.
- Defined:
  - Adds outputs stat_results[CNT_W-1:0] (pushes) and stat_exceptions[CNT_W-1:0] (pushes with invalid|overflow).
  - Both saturate at all-ones, reset to 0, and clear on flag_clr.
  - Same-cycle push and flag_clr -> counter = 1 for that event.
- Undefined: these ports and registers do not exist.

Decomposition:
- Package fpu_pkg: EXP_MAX=8'hFF, EXP_BIAS=127, QNAN_WORD, flag bit indices FLG_INV=2, FLG_OVF=1, FLG_ZERO=0.
- Sub-module fp32_pack: combinational field-to-word packer with flags. The top level holds the FIFO, handshake, sticky flags and counters.

Test Plan:
- Reset, then push {sign=0, exp=8'h80, frac=24'hC00000}, out_ready=1 -> next cycle out_data=32'h40400000, out_flags=0, one valid cycle.
- Push with in_error=1, exp=8'hFF, frac=24'h800000 -> out_data=32'h7FC00000, out_flags=3'b100, sticky_invalid=1 until flag_clr. flag_clr in the same cycle as a second error push -> sticky stays 1.
- Push {sign=1, overflow=1, exp=8'hFF} -> 32'hFF800000, flags 3'b010. Push {sign=1, exp=0} -> 32'h80000000, flags 3'b001.
- out_ready=0, push 3 back-to-back -> in_ready drops after 2 pushes, the third is held, out_data stable. Raise out_ready -> words emerge in order and in_ready returns one cycle after the first pop.
- Pulse rst_n low with 2 words buffered -> out_valid=0 immediately, in_ready=1, sticky flags 0. Under FMUL_PACK_STATS_EN, the counters are also 0.
- FMUL_PACK_STATS_EN with CNT_W=4: 17 pushes -> stat_results=4'hF (saturated). flag_clr -> 0.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared constants and types for the binary32 multiplier back end.
// Flag vectors are ordered {invalid, overflow, zero}.
package fpu_pkg;

   localparam logic [7:0]  EXP_MAX   = 8'hFF;
   localparam int          EXP_BIAS  = 127;
   localparam logic [31:0] QNAN_WORD = 32'h7FC00000;

   localparam int FLG_W    = 3;
   localparam int FLG_INV  = 2;
   localparam int FLG_OVF  = 1;
   localparam int FLG_ZERO = 0;

   typedef struct packed {
      logic [FLG_W-1:0] flags;
      logic [31:0]      word;
   } pack_entry_t;

   function automatic logic [31:0] fp32_inf(input logic sign);
      return {sign, EXP_MAX, 23'h0};
   endfunction

endpackage

// File: rtl/fp32_pack.sv
// Combinational packer: multiplier result fields to a binary32 word plus flags.
// Special cases are resolved in priority order error > overflow > inf > zero.
module fp32_pack
   import fpu_pkg::*;
#(
   parameter logic [31:0] QNAN = QNAN_WORD
) (
   input  logic             sign,
   input  logic [7:0]       exp_b,
   input  logic [23:0]      frac,
   input  logic             error,
   input  logic             overflow,
   output logic [31:0]      word,
   output logic [FLG_W-1:0] flags
);

   // The hidden bit is implied by a nonzero exponent and never stored.
   logic unused_hidden;
   assign unused_hidden = frac[23];

   always_comb begin
      word  = {sign, exp_b, frac[22:0]};
      flags = '0;
      if (error) begin
         // Upstream NaN fractions are zero, so raw packing would read as infinity.
         word           = QNAN;
         flags[FLG_INV] = 1'b1;
      end else if (overflow) begin
         word           = fp32_inf(sign);
         flags[FLG_OVF] = 1'b1;
      end else if (exp_b == EXP_MAX) begin
         word = fp32_inf(sign);
      end else if (exp_b == 8'h00) begin
         word            = {sign, 31'h0};
         flags[FLG_ZERO] = 1'b1;
      end
   end

endmodule

// File: rtl/fmul_result_pack.sv
// Multiplier result packer with an elastic output FIFO and sticky exception flags.
// Define FMUL_PACK_STATS_EN to add saturating result/exception counters.
module fmul_result_pack
   import fpu_pkg::*;
#(
   parameter int          DEPTH = 2,
   parameter logic [31:0] QNAN  = QNAN_WORD,
   parameter int          CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sign,
   input  logic [7:0]       in_exp,
   input  logic [23:0]      in_frac,
   input  logic             in_error,
   input  logic             in_overflow,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic [FLG_W-1:0] out_flags,
   input  logic             flag_clr,
   output logic             sticky_invalid,
   output logic             sticky_overflow
`ifdef FMUL_PACK_STATS_EN
   ,
   output logic [CNT_W-1:0] stat_results,
   output logic [CNT_W-1:0] stat_exceptions
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   pack_entry_t       mem_q [DEPTH];
   pack_entry_t       mem_d [DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              sticky_inv_q, sticky_inv_d;
   logic              sticky_ovf_q, sticky_ovf_d;

   logic [31:0]       pack_word;
   logic [FLG_W-1:0]  pack_flags;
   pack_entry_t       in_entry;
   pack_entry_t       head;
   logic              push;
   logic              pop;

   fp32_pack #(
      .QNAN (QNAN)
   ) u_pack (
      .sign     (in_sign),
      .exp_b    (in_exp),
      .frac     (in_frac),
      .error    (in_error),
      .overflow (in_overflow),
      .word     (pack_word),
      .flags    (pack_flags)
   );

   assign in_entry = '{flags: pack_flags, word: pack_word};

   // Ready depends only on registered occupancy, never on out_ready.
   assign in_ready  = (count_q != CW'(DEPTH));
   assign out_valid = (count_q != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   assign head            = mem_q[rd_ptr_q];
   assign out_data        = head.word;
   assign out_flags       = head.flags;
   assign sticky_invalid  = sticky_inv_q;
   assign sticky_overflow = sticky_ovf_q;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CW'(push) - CW'(pop);
      if (push) begin
         mem_d[wr_ptr_q] = in_entry;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
   end

   // A flag raised by this cycle's push survives a simultaneous clear.
   always_comb begin
      sticky_inv_d = (sticky_inv_q & ~flag_clr) | (push & in_entry.flags[FLG_INV]);
      sticky_ovf_d = (sticky_ovf_q & ~flag_clr) | (push & in_entry.flags[FLG_OVF]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         sticky_inv_q <= 1'b0;
         sticky_ovf_q <= 1'b0;
      end else begin
         mem_q        <= mem_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         sticky_inv_q <= sticky_inv_d;
         sticky_ovf_q <= sticky_ovf_d;
      end
   end

`ifdef FMUL_PACK_STATS_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] stat_res_q, stat_res_d;
   logic [CNT_W-1:0] stat_exc_q, stat_exc_d;
   logic             exc_push;

   assign exc_push = push & (in_entry.flags[FLG_INV] | in_entry.flags[FLG_OVF]);

   // A clear coinciding with an event restarts the count at that event.
   always_comb begin
      stat_res_d = stat_res_q;
      stat_exc_d = stat_exc_q;
      if (flag_clr) begin
         stat_res_d = CNT_W'(push);
         stat_exc_d = CNT_W'(exc_push);
      end else begin
         if (push && stat_res_q != CNT_MAX) begin
            stat_res_d = stat_res_q + CNT_W'(1);
         end
         if (exc_push && stat_exc_q != CNT_MAX) begin
            stat_exc_d = stat_exc_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_res_q <= '0;
         stat_exc_q <= '0;
      end else begin
         stat_res_q <= stat_res_d;
         stat_exc_q <= stat_exc_d;
      end
   end

   assign stat_results    = stat_res_q;
   assign stat_exceptions = stat_exc_q;
`else
   localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_fmul_result_pack.sv
// Scoreboard bench for fmul_result_pack: drivers queue expected words, a monitor checks pops.
// Counter checks are compiled in when FMUL_PACK_STATS_EN is defined.
module tb_fmul_result_pack;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [7:0]  in_exp;
   logic [23:0] in_frac;
   logic        in_error;
   logic        in_overflow;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [2:0]  out_flags;
   logic        flag_clr;
   logic        sticky_invalid;
   logic        sticky_overflow;
`ifdef FMUL_PACK_STATS_EN
   logic [3:0]  stat_results;
   logic [3:0]  stat_exceptions;
`endif

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [34:0] exp_q[$];
   bit          third_done;

   always #5 clk = ~clk;

`ifdef FMUL_PACK_STATS_EN
   fmul_result_pack #(.DEPTH(2), .QNAN(32'h7FC00000), .CNT_W(4)) dut (
`else
   fmul_result_pack #(.DEPTH(2), .QNAN(32'h7FC00000)) dut (
`endif
      .clk             (clk),
      .rst_n           (rst_n),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_sign         (in_sign),
      .in_exp          (in_exp),
      .in_frac         (in_frac),
      .in_error        (in_error),
      .in_overflow     (in_overflow),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_data        (out_data),
      .out_flags       (out_flags),
      .flag_clr        (flag_clr),
      .sticky_invalid  (sticky_invalid),
      .sticky_overflow (sticky_overflow)
`ifdef FMUL_PACK_STATS_EN
      ,
      .stat_results    (stat_results),
      .stat_exceptions (stat_exceptions)
`endif
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h", name, act, req);
      end
   endtask

   // Drive one result and queue its expected packed word once it is accepted.
   task automatic send(input logic s, input logic [7:0] e, input logic [23:0] f,
                       input logic err, input logic ovf, input logic clr,
                       input logic [31:0] w, input logic [2:0] fl);
      int waited = 0;
      @(negedge clk);
      in_sign     = s;
      in_exp      = e;
      in_frac     = f;
      in_error    = err;
      in_overflow = ovf;
      flag_clr    = clr;
      in_valid    = 1'b1;
      while (!in_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: word %h not accepted within 50 cycles", w);
         in_valid = 1'b0;
         flag_clr = 1'b0;
      end else begin
         exp_q.push_back({fl, w});
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         flag_clr = 1'b0;
      end
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("drain", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      flag_clr = 1'b1;
      @(negedge clk);
      flag_clr = 1'b0;
   endtask

   // Monitor: every accepted output word must match the head of the scoreboard.
   initial begin
      logic [34:0] e;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL out_unexpected: actual=%h required=none", {out_flags, out_data});
            end else begin
               e = exp_q.pop_front();
               check("out_word", {29'h0, out_flags, out_data}, {29'h0, e});
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      in_sign     = 1'b0;
      in_exp      = 8'h00;
      in_frac     = 24'h0;
      in_error    = 1'b0;
      in_overflow = 1'b0;
      out_ready   = 1'b1;
      flag_clr    = 1'b0;
      third_done  = 1'b0;

      repeat (2) @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_out_flags", 64'(out_flags), 64'd0);
      check("rst_sticky_inv", 64'(sticky_invalid), 64'd0);
      check("rst_sticky_ovf", 64'(sticky_overflow), 64'd0);
      rst_n = 1'b1;

      // 3.0: one word, one valid cycle
      send(1'b0, 8'h80, 24'hC00000, 1'b0, 1'b0, 1'b0, 32'h40400000, 3'b000);
      @(negedge clk);
      check("t1_valid", 64'(out_valid), 64'd1);
      @(negedge clk);
      check("t1_one_cycle", 64'(out_valid), 64'd0);

      // Invalid result, then invalid push coinciding with a clear
      send(1'b0, 8'hFF, 24'h800000, 1'b1, 1'b0, 1'b0, 32'h7FC00000, 3'b100);
      @(negedge clk);
      check("sticky_inv_set", 64'(sticky_invalid), 64'd1);
      check("sticky_ovf_quiet", 64'(sticky_overflow), 64'd0);
      send(1'b0, 8'hFF, 24'h800000, 1'b1, 1'b0, 1'b1, 32'h7FC00000, 3'b100);
      @(negedge clk);
      check("sticky_set_beats_clr", 64'(sticky_invalid), 64'd1);
      pulse_clr();
      check("sticky_inv_cleared", 64'(sticky_invalid), 64'd0);

      // Overflow, zero, inf*inf, hidden bit ignored, error beats overflow
      send(1'b1, 8'hFF, 24'h000000, 1'b0, 1'b1, 1'b0, 32'hFF800000, 3'b010);
      @(negedge clk);
      check("sticky_ovf_set", 64'(sticky_overflow), 64'd1);
      send(1'b1, 8'h00, 24'h123456, 1'b0, 1'b0, 1'b0, 32'h80000000, 3'b001);
      send(1'b0, 8'hFF, 24'h800000, 1'b0, 1'b0, 1'b0, 32'h7F800000, 3'b000);
      send(1'b1, 8'h7F, 24'hFFFFFF, 1'b0, 1'b0, 1'b0, 32'hBFFFFFFF, 3'b000);
      send(1'b1, 8'hFF, 24'h800000, 1'b1, 1'b1, 1'b0, 32'h7FC00000, 3'b100);
      drain();

      // Backpressure: fill, hold a third word, then release
      @(negedge clk);
      out_ready = 1'b0;
      send(1'b0, 8'h7F, 24'h800000, 1'b0, 1'b0, 1'b0, 32'h3F800000, 3'b000);
      send(1'b0, 8'h80, 24'h800000, 1'b0, 1'b0, 1'b0, 32'h40000000, 3'b000);
      fork
         begin
            send(1'b0, 8'h81, 24'hA00000, 1'b0, 1'b0, 1'b0, 32'h40A00000, 3'b000);
            third_done = 1'b1;
         end
      join_none
      @(negedge clk);
      check("full_in_ready", 64'(in_ready), 64'd0);
      check("full_out_valid", 64'(out_valid), 64'd1);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("hold_out_data", 64'(out_data), 64'h3F800000);
         check("hold_in_ready", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("ready_after_pop", 64'(in_ready), 64'd1);
      check("order_second", 64'(out_data), 64'h40000000);
      for (int i = 0; i < 50 && !third_done; i++) @(negedge clk);
      check("third_accepted", 64'(third_done), 64'd1);
      drain();

      // Reset with two words buffered
      @(negedge clk);
      out_ready = 1'b0;
      send(1'b0, 8'hFF, 24'h800000, 1'b1, 1'b0, 1'b0, 32'h7FC00000, 3'b100);
      send(1'b0, 8'h7F, 24'h800000, 1'b0, 1'b0, 1'b0, 32'h3F800000, 3'b000);
      @(negedge clk);
      check("pre_rst_sticky", 64'(sticky_invalid), 64'd1);
      check("pre_rst_full", 64'(in_ready), 64'd0);
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", 64'(out_valid), 64'd0);
      check("mid_rst_in_ready", 64'(in_ready), 64'd1);
      check("mid_rst_out_data", 64'(out_data), 64'd0);
      check("mid_rst_sticky", 64'(sticky_invalid), 64'd0);
`ifdef FMUL_PACK_STATS_EN
      check("mid_rst_stat_res", 64'(stat_results), 64'd0);
      check("mid_rst_stat_exc", 64'(stat_exceptions), 64'd0);
`endif
      exp_q.delete();
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      send(1'b0, 8'h80, 24'hC00000, 1'b0, 1'b0, 1'b0, 32'h40400000, 3'b000);
      drain();

`ifdef FMUL_PACK_STATS_EN
      pulse_clr();
      for (int i = 0; i < 17; i++) begin
         send(1'b0, 8'h80, 24'h800000, 1'b0, 1'b0, 1'b0, 32'h40000000, 3'b000);
      end
      @(negedge clk);
      check("stat_res_sat", 64'(stat_results), 64'hF);
      check("stat_exc_none", 64'(stat_exceptions), 64'd0);
      pulse_clr();
      check("stat_res_clr", 64'(stat_results), 64'd0);
      send(1'b0, 8'hFF, 24'h800000, 1'b1, 1'b0, 1'b1, 32'h7FC00000, 3'b100);
      @(negedge clk);
      check("stat_res_clr_push", 64'(stat_results), 64'd1);
      check("stat_exc_clr_push", 64'(stat_exceptions), 64'd1);
      drain();
`endif

      repeat (3) @(negedge clk);
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
